// File: rtl/vending_pkg.sv
// Shared constants and types for the vending-machine datapath (coin front end and
// the Moore controller that consumes its N/D pulses).
package vending_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int JAM_CYCLES_DEF      = 256;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_N,
    COIN_D
  } coin_t;

endpackage

// File: rtl/coin_detector_if.sv
// Coin-mech sensor lines in, conditioned coin pulses and jam flag out.
interface coin_detector_if;

  logic nickel_raw;
  logic dime_raw;
  logic N;
  logic D;
  logic jam;

  // master is the sensor/consumer side, slave is the coin_detector itself
  modport master (output nickel_raw, dime_raw, input N, D, jam);
  modport slave  (input nickel_raw, dime_raw, output N, D, jam);

endinterface

// File: rtl/coin_debounce.sv
// One sensor channel: two-flop synchroniser, stable-count debouncer, rising-edge
// pulse and a saturating high-time counter that flags a jammed sensor.
module coin_debounce
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int JAM_CYCLES      = JAM_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic rise,
  output logic level,
  output logic stuck
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int JW = $clog2(JAM_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] db_cnt;
  logic [JW-1:0] hi_cnt;
  logic          flip;
  logic          level_nxt;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    flip      = (s2 != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    level_nxt = level;
    if (flip) level_nxt = s2;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      hi_cnt <= '0;
      stuck  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;

      if (s2 == level || flip) db_cnt <= '0;
      else                     db_cnt <= db_cnt + DW'(1);

      level <= level_nxt;
      rise  <= flip && s2;

      if (!level)                        hi_cnt <= '0;
      else if (hi_cnt != JW'(JAM_CYCLES)) hi_cnt <= hi_cnt + JW'(1);

      // Looking at level_nxt lets the flag drop in the same edge the level falls.
      stuck <= level_nxt && (hi_cnt == JW'(JAM_CYCLES));
    end
  end

endmodule

// File: rtl/coin_detector.sv
// Coin front end: conditions nickel/dime sensors into exclusive single-cycle N/D
// pulses (dime wins a tie, nickel follows one cycle later) and a registered jam flag.
module coin_detector
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int JAM_CYCLES      = JAM_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  coin_detector_if.slave    bus
);

  logic  n_rise;
  logic  n_level;
  logic  n_stuck;
  logic  d_rise;
  logic  d_level;
  logic  d_stuck;
  coin_t grant;
  logic  pend_n;
  logic  jam_q;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_nickel (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (bus.nickel_raw),
    .rise  (n_rise),
    .level (n_level),
    .stuck (n_stuck)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_dime (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (bus.dime_raw),
    .rise  (d_rise),
    .level (d_level),
    .stuck (d_stuck)
  );

  // Levels are kept on the sub-module ports for observability; nothing here needs them.
  logic unused_levels;
  assign unused_levels = n_level ^ d_level;

  // NOTE: asynchronous active-low reset clears the pending nickel, so a coin in flight is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant  <= COIN_NONE;
      pend_n <= 1'b0;
      jam_q  <= 1'b0;
    end else begin
      if (d_rise) begin
        grant  <= COIN_D;
        pend_n <= n_rise || pend_n;
      end else if (n_rise || pend_n) begin
        grant  <= COIN_N;
        pend_n <= 1'b0;
      end else begin
        grant  <= COIN_NONE;
      end
      jam_q <= n_stuck || d_stuck;
    end
  end

  assign bus.N   = (grant == COIN_N);
  assign bus.D   = (grant == COIN_D);
  assign bus.jam = jam_q;

endmodule

// File: tb/tb_coin_detector.sv
// Directed bench for coin_detector: expected pulses go into a scoreboard queue when
// a sensor is driven and are matched by a negedge monitor against the N/D outputs.
module tb_coin_detector;
  import vending_pkg::*;

  typedef struct {
    int    cyc;
    coin_t coin;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;
  exp_t exp_q[$];

  coin_detector_if bus ();

  coin_detector dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: each pulse must match the head of the queue in cycle and coin.
  always @(negedge clk) begin
    exp_t  e;
    coin_t obs;
    if (rstn) begin
      if (bus.N || bus.D) begin
        check("n_d_exclusive", 32'(bus.N & bus.D), 32'd0);
        obs = bus.D ? COIN_D : COIN_N;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(obs), 32'(COIN_NONE));
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_coin", 32'(obs), 32'(e.coin));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missed_pulse", 32'(COIN_NONE), 32'(e.coin));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int r0;

    rstn = 1'b0;
    bus.nickel_raw = 1'b0;
    bus.dime_raw   = 1'b0;
    #1;
    check("reset_n",   32'(bus.N),   32'd0);
    check("reset_d",   32'(bus.D),   32'd0);
    check("reset_jam", 32'(bus.jam), 32'd0);
    idle(3);
    rstn = 1'b1;
    idle(3);

    // 1: nickel held 10 cycles -> single N six cycles after the first sampling edge
    c0 = cyc;
    bus.nickel_raw = 1'b1;
    exp_q.push_back('{c0 + 7, COIN_N});
    idle(10);
    bus.nickel_raw = 1'b0;
    idle(15);

    // 2: dime bounces 1,0,1,0 then settles high -> one D six cycles after the last rise
    bus.dime_raw = 1'b1; idle(1);
    bus.dime_raw = 1'b0; idle(1);
    bus.dime_raw = 1'b1; idle(1);
    bus.dime_raw = 1'b0; idle(1);
    c0 = cyc;
    bus.dime_raw = 1'b1;
    exp_q.push_back('{c0 + 7, COIN_D});
    idle(12);
    bus.dime_raw = 1'b0;
    idle(15);

    // 3: 3-cycle glitch on nickel never reaches the debounced level
    bus.nickel_raw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("glitch_level", 32'(dut.u_nickel.level), 32'd0);
    end
    bus.nickel_raw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("glitch_level", 32'(dut.u_nickel.level), 32'd0);
    end

    // 4: simultaneous insertion -> D first, N the following cycle
    c0 = cyc;
    bus.nickel_raw = 1'b1;
    bus.dime_raw   = 1'b1;
    exp_q.push_back('{c0 + 7, COIN_D});
    exp_q.push_back('{c0 + 8, COIN_N});
    idle(12);
    bus.nickel_raw = 1'b0;
    bus.dime_raw   = 1'b0;
    idle(15);

    // 5: dime held 300 cycles -> one D, jam after 6+256+1 cycles, drops 6 after release
    c0 = cyc;
    bus.dime_raw = 1'b1;
    exp_q.push_back('{c0 + 7, COIN_D});
    repeat (300) begin
      @(negedge clk);
      check("jam_rise", 32'(bus.jam), 32'(cyc >= c0 + 264));
    end
    r0 = cyc;
    bus.dime_raw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("jam_fall", 32'(bus.jam), 32'(cyc < r0 + 7));
    end
    idle(10);

    // 6: simultaneous insertion, reset during the D cycle -> pending N is dropped
    c0 = cyc;
    bus.nickel_raw = 1'b1;
    bus.dime_raw   = 1'b1;
    exp_q.push_back('{c0 + 7, COIN_D});
    idle(7);
    #2;
    rstn = 1'b0;
    bus.nickel_raw = 1'b0;
    bus.dime_raw   = 1'b0;
    #1;
    check("midreset_n",   32'(bus.N),   32'd0);
    check("midreset_d",   32'(bus.D),   32'd0);
    check("midreset_jam", 32'(bus.jam), 32'd0);
    idle(2);
    check("midreset_hold_n", 32'(bus.N), 32'd0);
    rstn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("no_pending_n", 32'(bus.N), 32'd0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
